// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect scheduler: FSM states,
// effect ids (numeric order equals priority) and the note table.
package sfx_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StPlay = 2'd2
    } state_e;

    localparam logic [1:0] IdNone   = 2'd0;
    localparam logic [1:0] IdSheep  = 2'd1;
    localparam logic [1:0] IdSword  = 2'd2;
    localparam logic [1:0] IdPlayer = 2'd3;

    localparam int unsigned PeriodW    = 8;
    localparam int unsigned EntryTickW = 4;
    localparam int unsigned NoteW      = PeriodW + EntryTickW;
    localparam int unsigned TableNotes = 4;

    // Indexed as SfxTable[id][note]; each entry is {period, ticks}.
    // Rows are listed id 3..0, notes within a row 3..0.
    localparam logic [3:0][3:0][NoteW-1:0] SfxTable = {
        {12'h608, 12'h904, 12'hC04, 12'hF04},  // player
        {12'h381, 12'h301, 12'h281, 12'h201},  // sword
        {12'h000, 12'h000, 12'h302, 12'h402},  // sheep
        {12'h000, 12'h000, 12'h000, 12'h000}   // none
    };

    // Highest-priority id among pending bits (bit 0 sheep .. bit 2 player).
    function automatic logic [1:0] top_id(input logic [2:0] pend);
        if (pend[2]) return IdPlayer;
        if (pend[1]) return IdSword;
        if (pend[0]) return IdSheep;
        return IdNone;
    endfunction

    // Pending-bit mask for an effect id.
    function automatic logic [2:0] id_mask(input logic [1:0] id);
        case (id)
            IdSheep:  return 3'b001;
            IdSword:  return 3'b010;
            IdPlayer: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Request/timebase inputs and oscillator-control outputs of the scheduler.
interface sfx_scheduler_if;
    import sfx_pkg::*;

    logic               tick;
    logic               req_sheep;
    logic               req_sword;
    logic               req_player;
    logic [PeriodW-1:0] period;
    logic               gate;
    logic               busy;
    logic [1:0]         active_id;
    logic               done;

    modport master (
        output tick, req_sheep, req_sword, req_player,
        input  period, gate, busy, active_id, done
    );

    modport slave (
        input  tick, req_sheep, req_sword, req_player,
        output period, gate, busy, active_id, done
    );

endinterface

// File: rtl/sfx_rom.sv
// Combinational effect-table lookup: (id, note_idx) -> {period, ticks}.
// Notes beyond the stored table read as a zero-tick terminator.
module sfx_rom
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_NOTES = 4,
    parameter int unsigned TICK_W    = 4,
    localparam int unsigned IdxW     = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic [1:0]         id,
    input  logic [IdxW-1:0]    note_idx,
    output logic [PeriodW-1:0] period,
    output logic [TICK_W-1:0]  ticks
);

    logic [NoteW-1:0] entry;
    logic [1:0]       idx2;

    // Select the table entry, falling back to all-zero past the table end.
    always_comb begin
        entry = '0;
        idx2  = 2'(note_idx);
        if (32'(note_idx) < TableNotes) begin
            entry = SfxTable[id][idx2];
        end
        period = entry[NoteW-1:EntryTickW];
        ticks  = TICK_W'(entry[EntryTickW-1:0]);
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: edge-detects three collision requests, arbitrates
// by priority with preemption, and steps through the selected effect's notes
// in units of the frame tick, driving the oscillator period and gate.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_NOTES = 4,
    parameter int unsigned TICK_W    = 4,
    localparam int unsigned IdxW     = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input logic           clk,
    input logic           reset,
    sfx_scheduler_if.slave bus
);

    state_e              state_q;
    logic [2:0]          req_q;
    logic [2:0]          pending_q;
    logic [2:0]          pending_d;
    logic [2:0]          req_now;
    logic [2:0]          req_edge;
    logic [2:0]          grant_mask;
    logic [1:0]          grant_id;
    logic [1:0]          active_id_q;
    logic                do_grant;
    logic [IdxW-1:0]     note_idx_q;
    logic [TICK_W-1:0]   dur_cnt_q;
    logic [TICK_W-1:0]   rom_ticks;
    logic [PeriodW-1:0]  period_q;
    logic [PeriodW-1:0]  rom_period;
    logic                gate_q;
    logic                done_q;

    sfx_rom #(
        .NUM_NOTES (NUM_NOTES),
        .TICK_W    (TICK_W)
    ) u_rom (
        .id       (active_id_q),
        .note_idx (note_idx_q),
        .period   (rom_period),
        .ticks    (rom_ticks)
    );

    // Edge detection, arbitration and next pending set.
    always_comb begin
        req_now    = {bus.req_player, bus.req_sword, bus.req_sheep};
        req_edge   = req_now & ~req_q;
        grant_id   = top_id(pending_q);
        grant_mask = id_mask(grant_id);
        // From IDLE any pending effect wins; during playback only a strictly
        // higher id can preempt (ids are numerically ordered by priority).
        if (state_q == StIdle) begin
            do_grant = (grant_id != IdNone);
        end else begin
            do_grant = (grant_id > active_id_q);
        end
        // New edges are merged after the clear so a re-request of the
        // granted effect stays pending and replays later.
        pending_d = (pending_q & ~(do_grant ? grant_mask : 3'b000)) | req_edge;
    end

    // Request history and pending bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= req_now;
            pending_q <= pending_d;
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            active_id_q <= IdNone;
            note_idx_q  <= '0;
            dur_cnt_q   <= '0;
            period_q    <= '0;
            gate_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (do_grant) begin
                // Grant or preemption; a coincident tick is deliberately dropped.
                state_q     <= StLoad;
                active_id_q <= grant_id;
                note_idx_q  <= '0;
                gate_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StLoad: begin
                        if (rom_ticks == '0) begin
                            state_q     <= StIdle;
                            active_id_q <= IdNone;
                            done_q      <= 1'b1;
                        end else begin
                            period_q  <= rom_period;
                            dur_cnt_q <= rom_ticks;
                            gate_q    <= 1'b1;
                            state_q   <= StPlay;
                        end
                    end
                    StPlay: begin
                        if (bus.tick) begin
                            dur_cnt_q <= dur_cnt_q - TICK_W'(1);
                            if (dur_cnt_q == TICK_W'(1)) begin
                                gate_q <= 1'b0;
                                if (note_idx_q == IdxW'(NUM_NOTES - 1)) begin
                                    state_q     <= StIdle;
                                    active_id_q <= IdNone;
                                    done_q      <= 1'b1;
                                end else begin
                                    note_idx_q <= note_idx_q + IdxW'(1);
                                    state_q    <= StLoad;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.period    = period_q;
    assign bus.gate      = gate_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.active_id = active_id_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios followed by random requests,
// ticks and resets, every cycle compared against a behavioural model.
module tb_sfx_scheduler;

    logic clk;
    logic reset;
    sfx_scheduler_if bus ();

    sfx_scheduler #(
        .NUM_NOTES (4),
        .TICK_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int tick_mode = 0;  // 0: every 10 cycles, 1: random, 2: manual
    int done_seen = 0;

    // Behavioural model: effect table and playback status.
    int tbl_per [4][4] = '{'{0, 0, 0, 0}, '{'h40, 'h30, 0, 0},
                           '{'h20, 'h28, 'h30, 'h38}, '{'hF0, 'hC0, 'h90, 'h60}};
    int tbl_tck [4][4] = '{'{0, 0, 0, 0}, '{2, 2, 0, 0},
                           '{1, 1, 1, 1}, '{4, 4, 4, 8}};
    int m_phase;   // 0 idle, 1 loading a note, 2 sounding a note
    int m_id;
    int m_note;
    int m_rem;
    int m_period;
    int m_gate;
    int m_done;
    bit [3:0] m_pend;
    bit [3:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_id = 0; m_note = 0; m_rem = 0;
        m_period = 0; m_gate = 0; m_done = 0; m_pend = '0; m_prev = '0;
    endtask

    task automatic model_end();
        m_phase = 0; m_id = 0; m_gate = 0; m_done = 1;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step();
        int best;
        bit [3:0] now;
        if (reset) begin
            model_reset();
        end else begin
            m_done = 0;
            best = 0;
            for (int id = 3; id >= 1; id--) begin
                if (best == 0 && m_pend[id]) best = id;
            end
            if ((m_phase == 0 && best != 0) || (m_phase != 0 && best > m_id)) begin
                m_pend[best] = 1'b0;
                m_id = best; m_note = 0; m_phase = 1; m_gate = 0;
            end else if (m_phase == 1) begin
                if (tbl_tck[m_id][m_note] == 0) begin
                    model_end();
                end else begin
                    m_period = tbl_per[m_id][m_note];
                    m_rem = tbl_tck[m_id][m_note];
                    m_gate = 1; m_phase = 2;
                end
            end else if (m_phase == 2 && bus.tick) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_gate = 0;
                    if (m_note == 3) begin
                        model_end();
                    end else begin
                        m_note++; m_phase = 1;
                    end
                end
            end
            now = {bus.req_player, bus.req_sword, bus.req_sheep, 1'b0};
            m_pend = m_pend | (now & ~m_prev);
            m_prev = now;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_period"}, 32'(bus.period), m_period);
        chk({tag, "_gate"}, 32'(bus.gate), m_gate);
        chk({tag, "_busy"}, 32'(bus.busy), 32'(m_phase != 0));
        chk({tag, "_active_id"}, 32'(bus.active_id), m_id);
        chk({tag, "_done"}, 32'(bus.done), m_done);
    endtask

    // Advance one clock, compare at the falling edge, then drive the tick.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        if (bus.done === 1'b1) done_seen++;
        cyc++;
        if (tick_mode == 0) bus.tick = (cyc % 10 == 9);
        else if (tick_mode == 1) bus.tick = ($urandom_range(0, 3) == 0);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        do begin
            cycle(tag);
            n++;
        end while (!(m_phase == 0 && m_pend == 0) && n < budget);
        chk({tag, "_in_budget"}, 32'(n < budget), 1);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    task automatic run_until(input string tag, input int phase, input int note, input int budget);
        int n = 0;
        while (!(m_phase == phase && m_note == note) && n < budget) begin
            cycle(tag);
            n++;
        end
        chk({tag, "_reached"}, 32'(n < budget), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period"}, 32'(bus.period), 0);
        chk({tag, "_gate"}, 32'(bus.gate), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_active_id"}, 32'(bus.active_id), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.tick = 1'b0;
        bus.req_sheep = 1'b0;
        bus.req_sword = 1'b0;
        bus.req_player = 1'b0;
        model_reset();
        cycle("rst");
        cycle("rst");
        check_zero("rst_state");
        reset = 1'b0;
        cycle("post_rst");

        // Sheep alone: two notes, then zero-tick terminator ends it.
        done_seen = 0;
        bus.req_sheep = 1'b1;
        cycle("sheep");
        bus.req_sheep = 1'b0;
        cycle("sheep");
        cycle("sheep");
        chk("sheep_first_gate", 32'(bus.gate), 1);
        chk("sheep_first_period", 32'(bus.period), 32'h40);
        run_until_idle("sheep", 300);
        chk("sheep_done_count", done_seen, 1);

        // Player preempts sword on note 1; sword is dropped silently.
        done_seen = 0;
        bus.req_sword = 1'b1;
        cycle("preempt");
        bus.req_sword = 1'b0;
        run_until("preempt", 2, 1, 200);
        bus.req_player = 1'b1;
        cycle("preempt");
        bus.req_player = 1'b0;
        cycle("preempt");
        chk("preempt_load_id", 32'(bus.active_id), 3);
        chk("preempt_load_gate", 32'(bus.gate), 0);
        cycle("preempt");
        chk("preempt_period", 32'(bus.period), 32'hF0);
        run_until_idle("preempt", 600);
        chk("preempt_done_count", done_seen, 1);

        // Sheep during player playback waits for player completion.
        done_seen = 0;
        bus.req_player = 1'b1;
        cycle("queue");
        bus.req_player = 1'b0;
        run_until("queue", 2, 0, 50);
        bus.req_sheep = 1'b1;
        cycle("queue");
        bus.req_sheep = 1'b0;
        run_until_idle("queue", 800);
        chk("queue_done_count", done_seen, 2);

        // All three at once: served player, sword, sheep.
        done_seen = 0;
        bus.req_sheep = 1'b1;
        bus.req_sword = 1'b1;
        bus.req_player = 1'b1;
        cycle("all3");
        bus.req_sheep = 1'b0;
        bus.req_sword = 1'b0;
        bus.req_player = 1'b0;
        run_until_idle("all3", 1000);
        chk("all3_done_count", done_seen, 3);

        // Reset mid sword note with request held high through release.
        done_seen = 0;
        bus.req_sword = 1'b1;
        run_until("rstmid", 2, 1, 200);
        cycle("rstmid");
        reset = 1'b1;
        #1;
        check_zero("rstmid_async");
        model_reset();
        cycle("rstmid");
        cycle("rstmid");
        reset = 1'b0;
        run_until_idle("rstmid", 300);
        chk("rstmid_done_count", done_seen, 1);
        bus.req_sword = 1'b0;
        cycle("rstmid");

        // Preemption coincides with the tick ending the last sword note.
        done_seen = 0;
        tick_mode = 2;
        bus.tick = 1'b0;
        bus.req_sword = 1'b1;
        cycle("coinc");
        bus.req_sword = 1'b0;
        for (int k = 0; k < 40 && !(m_phase == 2 && m_note == 3); k++) begin
            bus.tick = (m_phase == 2);
            cycle("coinc");
            bus.tick = 1'b0;
        end
        chk("coinc_on_last_note", 32'(m_phase == 2 && m_note == 3), 1);
        bus.req_player = 1'b1;
        cycle("coinc");
        bus.req_player = 1'b0;
        bus.tick = 1'b1;
        cycle("coinc");
        bus.tick = 1'b0;
        chk("coinc_id", 32'(bus.active_id), 3);
        chk("coinc_no_done", 32'(bus.done), 0);
        cycle("coinc");
        chk("coinc_period", 32'(bus.period), 32'hF0);
        for (int k = 0; k < 3; k++) begin
            bus.tick = 1'b1;
            cycle("coinc");
            bus.tick = 1'b0;
            cycle("coinc");
        end
        chk("coinc_still_note0", 32'(bus.gate), 1);
        tick_mode = 0;
        run_until_idle("coinc", 600);
        chk("coinc_done_count", done_seen, 1);

        // Random requests, ticks and occasional resets.
        tick_mode = 1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 24) == 0) bus.req_sheep = ~bus.req_sheep;
            if ($urandom_range(0, 24) == 0) bus.req_sword = ~bus.req_sword;
            if ($urandom_range(0, 29) == 0) bus.req_player = ~bus.req_player;
            reset = ($urandom_range(0, 599) == 0);
            cycle("rand");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
